// File: rtl/iob_native_rr_arbiter_pkg.sv
// Shared types and helpers for the native round-robin arbiter.
// Provides the FSM state encoding and the pointer-width calculation.
package iob_native_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // A single requester still needs a one-bit pointer so every port has a legal width.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_rr_prio_enc.sv
// Rotating priority encoder: finds the first set request after ptr, with wrap-around.
// Purely combinational; the caller owns the pointer register.
module iob_rr_prio_enc #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    logic [PTR_W-1:0] cand;

    // Visit ptr+1 .. ptr+N so the previous winner is considered last.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N; k++) begin
            cand = PTR_W'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/iob_native_rr_arbiter.sv
// Round-robin arbiter sharing one native slave port among N_MASTERS requesters.
// One request is latched at a time and held on the slave side until s_ready.
module iob_native_rr_arbiter
    import iob_native_rr_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_MASTERS-1:0]            m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
    output logic [DATA_W-1:0]               m_rdata,
    output logic [N_MASTERS-1:0]            m_ready,
    output logic                            s_valid,
    output logic [ADDR_W-1:0]               s_addr,
    output logic [DATA_W-1:0]               s_wdata,
    output logic [DATA_W/8-1:0]             s_wstrb,
    input  logic [DATA_W-1:0]               s_rdata,
    input  logic                            s_ready,
    output logic [N_MASTERS-1:0]            grant,
    output logic                            busy
);

    localparam int PTR_W  = ptr_width(N_MASTERS);
    localparam int STRB_W = DATA_W / 8;

    arb_state_t state_q;
    arb_state_t state_d;

    logic [PTR_W-1:0]     ptr_q;
    logic [N_MASTERS-1:0] win_onehot;
    logic [PTR_W-1:0]     win_idx;
    logic                 win_any;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wdata;
    logic [STRB_W-1:0]    win_wstrb;

    iob_rr_prio_enc #(
        .N     (N_MASTERS),
        .PTR_W (PTR_W)
    ) u_prio_enc (
        .req    (m_valid),
        .ptr    (ptr_q),
        .onehot (win_onehot),
        .idx    (win_idx),
        .any    (win_any)
    );

    always_comb begin
        win_addr  = m_addr[win_idx*ADDR_W +: ADDR_W];
        win_wdata = m_wdata[win_idx*DATA_W +: DATA_W];
        win_wstrb = m_wstrb[win_idx*STRB_W +: STRB_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (win_any) state_d = ST_BUSY;
            ST_BUSY: if (s_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Requests are captured only from IDLE; requester inputs are ignored while BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= PTR_W'(N_MASTERS - 1);
            grant   <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_wstrb <= '0;
        end else if (state_q == ST_IDLE) begin
            if (win_any) begin
                ptr_q   <= win_idx;
                grant   <= win_onehot;
                s_addr  <= win_addr;
                s_wdata <= win_wdata;
                s_wstrb <= win_wstrb;
            end
        end else if (s_ready) begin
            grant <= '0;
        end
    end

    always_comb begin
        busy    = (state_q == ST_BUSY);
        s_valid = (state_q == ST_BUSY);
        m_ready = '0;
        if (state_q == ST_BUSY && s_ready) begin
            m_ready = grant;
        end
    end

    assign m_rdata = s_rdata;

endmodule

// File: tb/tb_iob_native_rr_arbiter.sv
// Self-checking bench for iob_native_rr_arbiter: a two-master and a four-master instance.
// Expected grants/addresses/read data are queued at stimulus time and popped on each grant.
module tb_iob_native_rr_arbiter;

    typedef struct {
        logic [3:0]  grant;
        logic [31:0] addr;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [1:0]  m_valid = '0;
    logic [63:0] m_addr  = '0;
    logic [63:0] m_wdata = '0;
    logic [7:0]  m_wstrb = '0;
    logic [31:0] m_rdata;
    logic [1:0]  m_ready;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata = '0;
    logic        s_ready = 1'b0;
    logic [1:0]  grant;
    logic        busy;

    logic [3:0]   q_m_valid = '0;
    logic [127:0] q_m_addr  = '0;
    logic [127:0] q_m_wdata = '0;
    logic [15:0]  q_m_wstrb = '0;
    logic [31:0]  q_m_rdata;
    logic [3:0]   q_m_ready;
    logic         q_s_valid;
    logic [31:0]  q_s_addr;
    logic [31:0]  q_s_wdata;
    logic [3:0]   q_s_wstrb;
    logic [31:0]  q_s_rdata = '0;
    logic         q_s_ready = 1'b0;
    logic [3:0]   q_grant;
    logic         q_busy;

    always #5 clk = ~clk;

    iob_native_rr_arbiter #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .grant(grant), .busy(busy)
    );

    iob_native_rr_arbiter #(.N_MASTERS(4), .ADDR_W(32), .DATA_W(32)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .m_valid(q_m_valid), .m_addr(q_m_addr), .m_wdata(q_m_wdata), .m_wstrb(q_m_wstrb),
        .m_rdata(q_m_rdata), .m_ready(q_m_ready),
        .s_valid(q_s_valid), .s_addr(q_s_addr), .s_wdata(q_s_wdata), .s_wstrb(q_s_wstrb),
        .s_rdata(q_s_rdata), .s_ready(q_s_ready),
        .grant(q_grant), .busy(q_busy)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        m_valid = '0; q_m_valid = '0;
        s_ready = 1'b0; q_s_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Returns at a negedge with s_valid high, or ok=0 after the cycle budget.
    task automatic wait_sv2(output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_valid) begin
                ok = 1'b1;
                break;
            end
            cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_sv4(output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (q_s_valid) begin
                ok = 1'b1;
                break;
            end
            cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        tests_run++;
        if ({s_valid, grant, busy, m_ready} !== 6'b0 || {s_addr, s_wdata, s_wstrb} !== 68'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got sv=%b gr=%b busy=%b rdy=%b addr=%h want all zero",
                     s_valid, grant, busy, m_ready, s_addr);
        end
        tests_run++;
        if ({q_s_valid, q_grant, q_busy, q_m_ready} !== 10'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state4: got sv=%b gr=%b busy=%b want zero", q_s_valid, q_grant, q_busy);
        end
    endtask

    task automatic test_single_write();
        exp_t e;
        int   cyc;
        bit   ok;
        do_reset();
        m_addr[31:0]  = 32'h10;
        m_wdata[31:0] = 32'hA5A5A5A5;
        m_wstrb[3:0]  = 4'hF;
        m_valid       = 2'b01;
        exp_q.push_back('{grant: 4'b0001, addr: 32'h10, rdata: 32'h0BAD_F00D});
        wait_sv2(cyc, ok);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || cyc != 1) begin
            tests_failed++;
            $display("[TB] FAIL t1_latency: got ok=%0d cycles=%0d want ok=1 cycles=1", ok, cyc);
        end
        tests_run++;
        if (grant !== e.grant[1:0] || s_addr !== e.addr || s_wdata !== 32'hA5A5A5A5 ||
            s_wstrb !== 4'hF || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL t1_latch: got gr=%b addr=%h wd=%h st=%h busy=%b want gr=%b addr=%h wd=a5a5a5a5 st=f busy=1",
                     grant, s_addr, s_wdata, s_wstrb, busy, e.grant[1:0], e.addr);
        end
        @(posedge clk); #1 m_valid = 2'b00;
        @(posedge clk); #1 s_ready = 1'b1; s_rdata = e.rdata;
        @(negedge clk);
        tests_run++;
        if (m_ready !== e.grant[1:0] || m_rdata !== e.rdata) begin
            tests_failed++;
            $display("[TB] FAIL t1_ready: got rdy=%b rdata=%h want rdy=%b rdata=%h",
                     m_ready, m_rdata, e.grant[1:0], e.rdata);
        end
        @(posedge clk); #1 s_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({s_valid, grant, busy} !== 4'b0) begin
            tests_failed++;
            $display("[TB] FAIL t1_idle: got sv=%b gr=%b busy=%b want 0", s_valid, grant, busy);
        end
    endtask

    task automatic test_alternate();
        exp_t e;
        int   cyc;
        bit   ok;
        do_reset();
        m_addr  = {32'h104, 32'h100};
        m_wstrb = '0;
        m_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{grant: (i % 2 == 0) ? 4'b0001 : 4'b0010,
                              addr: (i % 2 == 0) ? 32'h100 : 32'h104,
                              rdata: 32'h1111_0000 + i});
        end
        for (int i = 0; i < 4; i++) begin
            wait_sv2(cyc, ok);
            e = exp_q.pop_front();
            tests_run++;
            if (!ok || cyc != 1 || grant !== e.grant[1:0] || s_addr !== e.addr) begin
                tests_failed++;
                $display("[TB] FAIL t2_grant%0d: got ok=%0d gap=%0d gr=%b addr=%h want gap=1 gr=%b addr=%h",
                         i, ok, cyc, grant, s_addr, e.grant[1:0], e.addr);
            end
            if (!ok) break;
            @(posedge clk); #1 s_ready = 1'b1; s_rdata = e.rdata;
            @(negedge clk);
            tests_run++;
            if (m_ready !== e.grant[1:0] || m_rdata !== e.rdata) begin
                tests_failed++;
                $display("[TB] FAIL t2_ready%0d: got rdy=%b rdata=%h want rdy=%b rdata=%h",
                         i, m_ready, m_rdata, e.grant[1:0], e.rdata);
            end
            @(posedge clk); #1 s_ready = 1'b0;
        end
        m_valid = 2'b00;
    endtask

    task automatic test_master1_read();
        exp_t e;
        int   cyc;
        bit   ok;
        bit   saw0 = 1'b0;
        @(posedge clk); #1;
        m_addr[63:32] = 32'h30;
        m_wstrb       = '0;
        m_valid       = 2'b10;
        exp_q.push_back('{grant: 4'b0010, addr: 32'h30, rdata: 32'hDEADBEEF});
        wait_sv2(cyc, ok);
        e = exp_q.pop_front();
        saw0 |= m_ready[0];
        @(posedge clk); #1 s_ready = 1'b1; s_rdata = e.rdata;
        @(negedge clk);
        saw0 |= m_ready[0];
        tests_run++;
        if (!ok || m_ready !== e.grant[1:0] || m_rdata !== e.rdata || s_addr !== e.addr) begin
            tests_failed++;
            $display("[TB] FAIL t3_read: got ok=%0d rdy=%b rdata=%h addr=%h want rdy=%b rdata=%h addr=%h",
                     ok, m_ready, m_rdata, s_addr, e.grant[1:0], e.rdata, e.addr);
        end
        @(posedge clk); #1 s_ready = 1'b0; m_valid = 2'b00;
        @(negedge clk);
        saw0 |= m_ready[0];
        tests_run++;
        if (saw0 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL t3_no_ready0: got m_ready[0] seen=%b want 0", saw0);
        end
    endtask

    task automatic test_drop_while_busy();
        exp_t e;
        int   cyc;
        bit   ok;
        bit   addr_bad = 1'b0;
        @(posedge clk); #1;
        m_addr[31:0]  = 32'h10;
        m_wdata[31:0] = 32'h1234_5678;
        m_wstrb[3:0]  = 4'h3;
        m_valid       = 2'b01;
        exp_q.push_back('{grant: 4'b0001, addr: 32'h10, rdata: 32'h5555_AAAA});
        wait_sv2(cyc, ok);
        e = exp_q.pop_front();
        @(posedge clk); #1 m_valid = 2'b00; m_addr[31:0] = 32'h20;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (s_addr !== e.addr || s_valid !== 1'b1) addr_bad = 1'b1;
            @(posedge clk); #1;
        end
        tests_run++;
        if (!ok || addr_bad) begin
            tests_failed++;
            $display("[TB] FAIL t4_hold: got ok=%0d addr_bad=%b addr=%h want addr=%h held", ok, addr_bad, s_addr, e.addr);
        end
        s_ready = 1'b1; s_rdata = e.rdata;
        @(negedge clk);
        tests_run++;
        if (m_ready !== e.grant[1:0] || m_rdata !== e.rdata) begin
            tests_failed++;
            $display("[TB] FAIL t4_ready: got rdy=%b rdata=%h want rdy=%b rdata=%h", m_ready, m_rdata, e.grant[1:0], e.rdata);
        end
        @(posedge clk); #1 s_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   cyc;
        bit   ok;
        m_addr  = {32'h204, 32'h200};
        m_wstrb = '0;
        m_valid = 2'b10;
        wait_sv2(cyc, ok);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (!ok || {s_valid, grant, busy} !== 4'b0) begin
            tests_failed++;
            $display("[TB] FAIL t5_async: got ok=%0d sv=%b gr=%b busy=%b want 0", ok, s_valid, grant, busy);
        end
        @(posedge clk); #1 rst_n = 1'b1; m_valid = 2'b11;
        exp_q.push_back('{grant: 4'b0001, addr: 32'h200, rdata: 32'h7777_0001});
        wait_sv2(cyc, ok);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || grant !== e.grant[1:0] || s_addr !== e.addr) begin
            tests_failed++;
            $display("[TB] FAIL t5_first: got ok=%0d gr=%b addr=%h want gr=%b addr=%h", ok, grant, s_addr, e.grant[1:0], e.addr);
        end
        @(posedge clk); #1 s_ready = 1'b1; s_rdata = e.rdata; m_valid = 2'b00;
        @(posedge clk); #1 s_ready = 1'b0;
        @(posedge clk); #1 s_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (m_ready !== 2'b00 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL t5_idle_ready: got rdy=%b busy=%b want 00 0", m_ready, busy);
        end
        @(posedge clk); #1 s_ready = 1'b0;
    endtask

    task automatic test_four_masters();
        exp_t e;
        int   cyc;
        bit   ok;
        do_reset();
        for (int i = 0; i < 4; i++) q_m_addr[i*32 +: 32] = 32'h1000 + 32'(i * 4);
        q_m_wstrb = '0;
        q_m_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{grant: 4'b0001 << (i % 4), addr: 32'h1000 + 32'((i % 4) * 4),
                              rdata: 32'hC0DE_0000 + i});
        end
        for (int i = 0; i < 8; i++) begin
            wait_sv4(cyc, ok);
            e = exp_q.pop_front();
            tests_run++;
            if (!ok || cyc != 1 || q_grant !== e.grant || q_s_addr !== e.addr) begin
                tests_failed++;
                $display("[TB] FAIL t6_grant%0d: got ok=%0d gap=%0d gr=%b addr=%h want gap=1 gr=%b addr=%h",
                         i, ok, cyc, q_grant, q_s_addr, e.grant, e.addr);
            end
            if (!ok) break;
            @(posedge clk); #1 q_s_ready = 1'b1; q_s_rdata = e.rdata;
            @(negedge clk);
            tests_run++;
            if (q_m_ready !== e.grant || q_m_rdata !== e.rdata) begin
                tests_failed++;
                $display("[TB] FAIL t6_ready%0d: got rdy=%b rdata=%h want rdy=%b rdata=%h",
                         i, q_m_ready, q_m_rdata, e.grant, e.rdata);
            end
            @(posedge clk); #1 q_s_ready = 1'b0;
            if (i == 7) q_m_valid = 4'h0;
        end
        @(posedge clk); #1 q_s_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (q_m_ready !== 4'b0 || q_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL t6_idle_ready: got rdy=%b busy=%b want 0000 0", q_m_ready, q_busy);
        end
        @(posedge clk); #1 q_s_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_alternate();
        test_master1_read();
        test_drop_while_busy();
        test_reset_mid();
        test_four_masters();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
